// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, default line settings and bit-timing derivation shared by UART blocks
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int CLOCK_FREQ_DEF = 125_000_000;
    localparam int BAUD_RATE_DEF  = 115_200;
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction
    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return (clock_freq / baud_rate) / 2;
    endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte valid/ready handshake
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    modport master (output data_out, data_out_valid, input data_out_ready);
    modport slave (input data_out, data_out_valid, output data_out_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling and a valid/ready output byte
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEF,
    parameter int BAUD_RATE  = BAUD_RATE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    uart_receiver_if.master rx_if,
    output logic frame_err,
    output logic overrun,
    output logic rx_busy
);
    localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SMP = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(SET);
    localparam logic [CW-1:0] EDGE_LAST = CW'(SET - 1);
    localparam logic [CW-1:0] SMP_LAST  = CW'(SMP - 1);

    logic rx_s;
    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, data_out_q, data_out_d;
    logic rx_prev_q, rx_prev_d, valid_q, valid_d;
    logic frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
    logic bit_end, held;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(serial_in), .q(rx_s));

    assign rx_if.data_out       = data_out_q;
    assign rx_if.data_out_valid = valid_q;
    assign frame_err            = frame_err_q;
    assign overrun              = overrun_q;
    assign rx_busy              = busy_q;
    assign bit_end              = cnt_q == EDGE_LAST;
    assign held                 = valid_q && !rx_if.data_out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE || bit_end) ? cnt_q : cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        valid_d     = held;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rx_prev_d   = rx_s;
        case (state_q)
            IDLE: if (rx_prev_q && !rx_s) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (cnt_q == SMP_LAST) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = '0;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d[idx_q] = rx_s;
                cnt_d          = '0;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                state_d     = IDLE;
                cnt_d       = '0;
                frame_err_d = !rx_s;
                overrun_d   = rx_s && held;
                // a held byte wins; the new one is dropped and flagged as overrun
                data_out_d  = (rx_s && !held) ? shift_q : data_out_q;
                valid_d     = held || rx_s;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_out_q  <= 8'h00;
            rx_prev_q   <= 1'b1;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            rx_prev_q   <= rx_prev_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a byte-queue scoreboard with a decoupled monitor
module tb_uart_receiver;
    import uart_pkg::*;
    localparam int CF  = 1_000_000;
    localparam int BR  = 62_500;
    localparam int SET = symbol_edge_time(CF, BR);
    localparam int SMP = sample_time(CF, BR);

    logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1;
    logic frame_err, overrun, rx_busy;
    uart_receiver_if bus ();

    uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .rx_if(bus.master),
        .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
    int valid_rises = 0, valid_cycles = 0, valid_rise_cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every handshake and tracks pulse outputs
    initial begin
        logic fe_prev, ov_prev, v_prev;
        logic [7:0] e;
        fe_prev = 0; ov_prev = 0; v_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err) begin
                    fe_cnt++;
                    chk("frame_err_one_cycle", {31'd0, fe_prev}, 0);
                end
                if (overrun) begin
                    ov_cnt++;
                    chk("overrun_one_cycle", {31'd0, ov_prev}, 0);
                end
                if (bus.data_out_valid && !v_prev) begin
                    valid_rises++;
                    valid_rise_cyc = cyc;
                end
                if (bus.data_out_valid) valid_cycles++;
                if (bus.data_out_valid && bus.data_out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", {24'd0, bus.data_out}, {24'd0, e});
                    end
                end
            end
            fe_prev = frame_err && !rst;
            ov_prev = overrun && !rst;
            v_prev  = bus.data_out_valid && !rst;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (SET) @(posedge clk);
        #1;
    endtask

    // abort_at >= 0 asserts rst halfway through that data bit and returns with rst held
    task automatic send(input logic [7:0] b, input logic stop_bit, input int abort_at);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                serial_in = b[i];
                repeat (SET / 2) @(posedge clk);
                #1 rst = 1'b1;
                serial_in = 1'b1;
                return;
            end
            drive_bit(b[i]);
        end
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, vr, vc, lat, fe0;
        logic [7:0] b;
        logic busy_mid, busy_end;
        bus.data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", {24'd0, bus.data_out}, 0);
        chk("reset_valid", {31'd0, bus.data_out_valid}, 0);
        chk("reset_busy", {31'd0, rx_busy}, 0);
        rst = 1'b0;
        idle(5);

        // single byte: latency and single-cycle valid
        vc = valid_cycles;
        t0 = cyc;
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1, -1);
        idle(SET);
        lat = valid_rise_cyc - t0;
        checks++;
        if (lat < 9 * SET + SET / 2 - 2 || lat > 9 * SET + SET / 2 + 8) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected about %0d", lat, 9 * SET + SET / 2);
        end
        chk("valid_cycles_41", valid_cycles - vc, 1);

        // back-to-back random frames
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(b, 1'b1, -1);
        end
        idle(2 * SET);

        // false start: short glitch must not leave IDLE past the sample point
        vr = valid_rises;
        serial_in = 1'b0;
        busy_mid = 0; busy_end = 1;
        for (int i = 0; i < 3 * SET; i++) begin
            if (i == 4) serial_in = 1'b1;
            @(negedge clk);
            if (i == 5) busy_mid = rx_busy;
            if (i == SMP + 3) busy_end = rx_busy;
        end
        @(posedge clk);
        #1;
        chk("glitch_busy_mid", {31'd0, busy_mid}, 1);
        chk("glitch_busy_idle", {31'd0, busy_end}, 0);
        chk("glitch_no_valid", valid_rises - vr, 0);

        // bad stop bit then break held low
        vr = valid_rises;
        fe0 = fe_cnt;
        exp_fe++;
        send(8'hA5, 1'b0, -1);
        idle(0);
        serial_in = 1'b0;
        repeat (3 * SET) @(posedge clk);
        #1;
        idle(2 * SET);
        chk("break_frame_err_count", fe_cnt - fe0, 1);
        chk("break_no_valid", valid_rises - vr, 0);

        // overrun: second byte dropped while first held
        bus.data_out_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_ov++;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        idle(SET);
        chk("overrun_hold_data", {24'd0, bus.data_out}, 32'h11);
        chk("overrun_hold_valid", {31'd0, bus.data_out_valid}, 1);
        chk("overrun_count", ov_cnt, 1);
        bus.data_out_ready = 1'b1;
        @(posedge clk);
        #1 bus.data_out_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop_after_ready", {31'd0, bus.data_out_valid}, 0);
        bus.data_out_ready = 1'b1;
        idle(SET);

        // reset mid-frame, then a clean frame
        send(8'h77, 1'b1, 4);
        repeat (3) @(negedge clk);
        chk("midreset_data_out", {24'd0, bus.data_out}, 0);
        chk("midreset_valid", {31'd0, bus.data_out_valid}, 0);
        chk("midreset_busy", {31'd0, rx_busy}, 0);
        chk("midreset_err", {30'd0, frame_err, overrun}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * SET);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, -1);
        idle(SET);

        // random frames with random idle gaps
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(b, 1'b1, -1);
            idle($urandom_range(0, 40));
        end

        for (int i = 0; i < 4 * SET && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_frame_err", fe_cnt, exp_fe);
        chk("total_overrun", ov_cnt, exp_ov);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
